// File: rtl/mig7_ui_model_if.sv
// MIG 7-series app_* user interface bundle: master = initiator, slave = controller model.
// Pure wiring; all handshakes are valid/ready (app_en/app_rdy, app_wdf_wren/app_wdf_rdy).
interface mig7_ui_model_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic                    app_wdf_rdy;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;
    logic                    app_ref_req;
    logic                    app_ref_ack;
    logic                    app_zq_req;
    logic                    app_zq_ack;
    logic                    app_sr_req;
    logic                    app_sr_active;
    logic                    init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_ref_req, app_zq_req, app_sr_req,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  app_ref_ack, app_zq_ack, app_sr_active, init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_ref_req, app_zq_req, app_sr_req,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output app_ref_ack, app_zq_ack, app_sr_active, init_calib_complete
    );
endinterface

// File: rtl/mig7_ui_model.sv
// Behavioural MIG 7-series app_* responder over on-chip RAM; reads return RD_LATENCY+1 cycles after acceptance.
// Backpressure: app_rdy drops while the single command slot is busy, in self-refresh, or on stall; app_wdf_rdy drops when the 4-deep data FIFO is full.

module mig7_ui_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module mig7_ui_model #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 128,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int CALIB_CYCLES   = 64,
    parameter int RD_LATENCY     = 4,
    parameter int STALL_EVERY    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mig7_ui_model_if.slave app
);
    localparam int         MASK_WIDTH = DATA_WIDTH / 8;
    localparam int         CAL_W      = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0] CMD_WR     = 3'b000;
    localparam logic [2:0] CMD_RD     = 3'b001;

    logic [CAL_W-1:0]          cal_cnt;
    logic                      calib_done;
    logic                      stall;
    logic                      sr_active;
    logic [1:0]                ref_pend;
    logic [1:0]                zq_pend;
    logic                      ref_ack;
    logic                      zq_ack;

    logic                      slot_vld;
    logic [2:0]                slot_cmd;
    logic [MEM_DEPTH_LOG2-1:0] slot_idx;
    logic                      cmd_rdy;
    logic                      cmd_acc;
    logic                      exec;
    logic                      exec_rd;
    logic                      exec_wr;

    logic                      wdf_rdy;
    logic                      wdf_push;
    logic                      wdf_full;
    logic                      wdf_empty;
    logic [MASK_WIDTH+DATA_WIDTH-1:0] wdf_pop_dat;
    logic [MASK_WIDTH-1:0]     wr_mask;
    logic [DATA_WIDTH-1:0]     wr_dat;

    logic [DATA_WIDTH-1:0]     ram [1 << MEM_DEPTH_LOG2];
    logic [DATA_WIDTH-1:0]     ram_q;
    logic [RD_LATENCY:0]       rd_vld;
    logic [DATA_WIDTH-1:0]     rd_dat [1:RD_LATENCY];

    // Address bits outside the word index and wdf_end carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{app.app_addr, app.app_wdf_end};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_cnt    <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) calib_done <= 1'b1;
            cal_cnt <= cal_cnt + 1'b1;
        end
    end

    generate
        if (STALL_EVERY != 0) begin : g_stall
            localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
            logic [SW-1:0] stall_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                 stall_cnt <= '0;
                else if (stall_cnt == SW'(STALL_EVERY - 1)) stall_cnt <= '0;
                else                                        stall_cnt <= stall_cnt + 1'b1;
            end
            assign stall = (stall_cnt == SW'(STALL_EVERY - 1));
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // Two-stage delay per maintenance channel; a request arriving while one is in flight is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pend  <= '0;
            zq_pend   <= '0;
            ref_ack   <= 1'b0;
            zq_ack    <= 1'b0;
            sr_active <= 1'b0;
        end else begin
            ref_pend  <= {ref_pend[0], app.app_ref_req & ~|ref_pend};
            zq_pend   <= {zq_pend[0],  app.app_zq_req  & ~|zq_pend};
            ref_ack   <= ref_pend[1];
            zq_ack    <= zq_pend[1];
            sr_active <= app.app_sr_req;
        end
    end

    assign cmd_rdy  = calib_done & ~slot_vld & ~sr_active & ~stall;
    assign cmd_acc  = app.app_en & cmd_rdy;
    assign wdf_rdy  = calib_done & ~wdf_full;
    assign wdf_push = app.app_wdf_wren & wdf_rdy;

    // A write parks in the slot until its data beat is in the FIFO
    assign exec    = slot_vld & ((slot_cmd != CMD_WR) | ~wdf_empty);
    assign exec_rd = exec & (slot_cmd == CMD_RD);
    assign exec_wr = exec & (slot_cmd == CMD_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= 1'b0;
            slot_cmd <= '0;
            slot_idx <= '0;
        end else if (cmd_acc) begin
            slot_vld <= 1'b1;
            slot_cmd <= app.app_cmd;
            slot_idx <= app.app_addr[3 +: MEM_DEPTH_LOG2];
        end else if (exec) begin
            slot_vld <= 1'b0;
        end
    end

    mig7_ui_fifo #(
        .WIDTH      (MASK_WIDTH + DATA_WIDTH),
        .DEPTH_LOG2 (2)
    ) u_wdf_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wdf_push),
        .push_dat ({app.app_wdf_mask, app.app_wdf_data}),
        .pop      (exec_wr),
        .pop_dat  (wdf_pop_dat),
        .full     (wdf_full),
        .empty    (wdf_empty)
    );

    assign {wr_mask, wr_dat} = wdf_pop_dat;

    // Backing store is deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wr_mask[b]) ram[slot_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
        end
        if (exec_rd) ram_q <= ram[slot_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
            for (int i = 1; i <= RD_LATENCY; i++) rd_dat[i] <= '0;
        end else begin
            rd_vld <= {rd_vld[RD_LATENCY-1:0], exec_rd};
            if (rd_vld[0]) rd_dat[1] <= ram_q;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                if (rd_vld[i-1]) rd_dat[i] <= rd_dat[i-1];
            end
        end
    end

    assign app.app_rdy             = cmd_rdy;
    assign app.app_wdf_rdy         = wdf_rdy;
    assign app.app_rd_data         = rd_dat[RD_LATENCY];
    assign app.app_rd_data_valid   = rd_vld[RD_LATENCY];
    assign app.app_rd_data_end     = rd_vld[RD_LATENCY];
    assign app.app_ref_ack         = ref_ack;
    assign app.app_zq_ack          = zq_ack;
    assign app.app_sr_active       = sr_active;
    assign app.init_calib_complete = calib_done;
endmodule

// File: tb/tb_mig7_ui_model.sv
// Directed bench for mig7_ui_model: a scoreboard queue holds expected read data and due cycle,
// checked every cycle on the falling edge; a second instance with STALL_EVERY=4 covers stalls.
module tb_mig7_ui_model;
    localparam int AW           = 28;
    localparam int DW           = 128;
    localparam int RD_LATENCY   = 4;
    localparam int CALIB_CYCLES = 64;

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mig7_ui_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app ();
    mig7_ui_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app_st ();

    mig7_ui_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10),
        .CALIB_CYCLES(CALIB_CYCLES), .RD_LATENCY(RD_LATENCY), .STALL_EVERY(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .app   (app)
    );

    mig7_ui_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10),
        .CALIB_CYCLES(CALIB_CYCLES), .RD_LATENCY(RD_LATENCY), .STALL_EVERY(4)
    ) dut_st (
        .clk   (clk),
        .rst_n (rst_n),
        .app   (app_st)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rd();
        if (sb.size() == 0) begin
            chk("rd_spurious", {app.app_rd_data_valid, app.app_rd_data_end}, '0);
        end else if (app.app_rd_data_valid) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data", app.app_rd_data, e.dat);
            chk("rd_latency", cyc, e.due);
            chk("rd_end", app.app_rd_data_end, 1);
        end else begin
            chk("rd_overdue", cyc < sb[0].due, 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_rd();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_calib(input string tag);
        int   n;
        logic early;
        n = 0;
        early = 1'b0;
        while (!app.init_calib_complete && n < 200) begin
            early |= app.app_rdy | app.app_wdf_rdy;
            tick();
            n++;
        end
        chk({tag, "_cycles"}, n, CALIB_CYCLES);
        chk({tag, "_rdy_early"}, early, 0);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
        int w;
        w = 0;
        app.app_cmd  = c;
        app.app_addr = a;
        app.app_en   = 1'b1;
        while (!app.app_rdy && w < 100) begin
            tick();
            w++;
        end
        chk("cmd_wait", w < 100, 1);
        tick();
        acc = cyc;
        app.app_en = 1'b0;
    endtask

    task automatic wr_data(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        int w;
        w = 0;
        app.app_wdf_data = d;
        app.app_wdf_mask = m;
        app.app_wdf_wren = 1'b1;
        app.app_wdf_end  = 1'b1;
        while (!app.app_wdf_rdy && w < 100) begin
            tick();
            w++;
        end
        chk("wdf_wait", w < 100, 1);
        tick();
        app.app_wdf_wren = 1'b0;
        app.app_wdf_end  = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        int acc;
        wr_data(d, m);
        cmd(3'b000, a, acc);
    endtask

    task automatic read_exp(input logic [AW-1:0] a, input logic [DW-1:0] e);
        int   acc;
        exp_t x;
        cmd(3'b001, a, acc);
        x.dat = e;
        x.due = acc + RD_LATENCY + 1;
        sb.push_back(x);
    endtask

    initial begin
        int            acc;
        int            lows;
        int            last;
        logic          gap_ok;
        logic          seen;
        logic [DW-1:0] dead;
        logic [DW-1:0] late;
        logic [DW-1:0] fd [4];

        dead = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        late = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
        for (int k = 0; k < 4; k++)
            fd[k] = {32'hC0DE_0000 + 32'(k), 32'h1234_5678, ~32'(k), 32'hA5A5_5A5A ^ 32'(k)};

        app.app_addr = '0;    app.app_cmd = '0;      app.app_en = 1'b0;
        app.app_wdf_data = '0; app.app_wdf_mask = '0; app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0;
        app.app_ref_req = 1'b0; app.app_zq_req = 1'b0; app.app_sr_req = 1'b0;
        app_st.app_addr = '0;    app_st.app_cmd = '0;      app_st.app_en = 1'b0;
        app_st.app_wdf_data = '0; app_st.app_wdf_mask = '0; app_st.app_wdf_wren = 1'b0; app_st.app_wdf_end = 1'b0;
        app_st.app_ref_req = 1'b0; app_st.app_zq_req = 1'b0; app_st.app_sr_req = 1'b0;

        // Reset values and calibration
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ctrl", {app.app_rdy, app.app_wdf_rdy, app.app_rd_data_valid, app.app_rd_data_end,
                         app.app_ref_ack, app.app_zq_ack, app.app_sr_active, app.init_calib_complete}, '0);
        chk("rst_rd_data", app.app_rd_data, '0);
        rst_n = 1'b1;
        wait_calib("cal");
        chk("cal_rdy", {app.app_rdy, app.app_wdf_rdy}, 2'b11);

        // Stall instance: one low cycle in every four
        lows = 0;
        last = -1;
        gap_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!app_st.app_rdy) begin
                if (last >= 0 && i - last != 4) gap_ok = 1'b0;
                last = i;
                lows++;
            end
            tick();
        end
        chk("stall_lows", lows, 4);
        chk("stall_gap", gap_ok, 1);

        // Write then read, plus one-command-per-two-cycles throughput
        write(28'h08, dead, '0);
        read_exp(28'h08, dead);
        chk("thru_rdy_low", app.app_rdy, 0);
        tick();
        chk("thru_rdy_back", app.app_rdy, 1);
        drain(8);

        // Byte mask
        write(28'h10, {DW{1'b1}}, '0);
        write(28'h10, '0, 16'h00FF);
        read_exp(28'h10, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        drain(8);

        // Write command whose data shows up five cycles late
        cmd(3'b000, 28'h20, acc);
        seen = 1'b0;
        repeat (5) begin
            seen |= app.app_rdy;
            tick();
        end
        chk("late_rdy_hold", seen, 0);
        wr_data(late, '0);
        chk("late_rdy_at_pop", app.app_rdy, 0);
        tick();
        chk("late_rdy_after_pop", app.app_rdy, 1);
        read_exp(28'h20, late);
        drain(8);

        // Data FIFO fill ahead of commands
        for (int k = 0; k < 4; k++) begin
            wr_data(fd[k], '0);
            if (k == 2) chk("fifo_not_full", app.app_wdf_rdy, 1);
        end
        chk("fifo_full", app.app_wdf_rdy, 0);
        for (int k = 0; k < 4; k++) cmd(3'b000, AW'(k * 8), acc);
        chk("fifo_drained_rdy", app.app_wdf_rdy, 1);
        for (int k = 0; k < 4; k++) read_exp(AW'(k * 8), fd[k]);
        drain(8);

        // Refresh: single-cycle request
        app.app_ref_req = 1'b1;
        tick();
        app.app_ref_req = 1'b0;
        chk("ref_ack_n0", app.app_ref_ack, 0);
        tick();
        chk("ref_ack_n1", app.app_ref_ack, 0);
        tick();
        chk("ref_ack_n2", app.app_ref_ack, 1);
        tick();
        chk("ref_ack_n3", app.app_ref_ack, 0);

        // ZQ: two-cycle request, the second sample is absorbed
        app.app_zq_req = 1'b1;
        tick();
        chk("zq_ack_n0", app.app_zq_ack, 0);
        tick();
        app.app_zq_req = 1'b0;
        chk("zq_ack_n1", app.app_zq_ack, 0);
        tick();
        chk("zq_ack_n2", app.app_zq_ack, 1);
        tick();
        chk("zq_ack_n3", app.app_zq_ack, 0);
        tick();
        chk("zq_ack_n4", app.app_zq_ack, 0);

        // Self-refresh blocks command acceptance
        chk("sr_pre_rdy", app.app_rdy, 1);
        app.app_sr_req = 1'b1;
        tick();
        chk("sr_active", app.app_sr_active, 1);
        app.app_cmd  = 3'b001;
        app.app_addr = 28'h08;
        app.app_en   = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            seen |= app.app_rdy;
            tick();
        end
        seen |= app.app_rdy;
        chk("sr_rdy_held", seen, 0);
        app.app_en     = 1'b0;
        app.app_sr_req = 1'b0;
        tick();
        chk("sr_exit_active", app.app_sr_active, 0);
        chk("sr_exit_rdy", app.app_rdy, 1);

        // Reset two cycles after a read is accepted: that read never returns
        cmd(3'b001, 28'h20, acc);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {app.app_rdy, app.app_wdf_rdy, app.app_rd_data_valid, app.app_rd_data_end,
                            app.app_ref_ack, app.app_zq_ack, app.app_sr_active, app.init_calib_complete}, '0);
        chk("midrst_rd_data", app.app_rd_data, '0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_calib("recal");
        read_exp(28'h20, late);
        read_exp(28'h08, fd[1]);
        drain(12);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
